// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int INST_W = 32;
    localparam int XLEN   = 64;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    // BOOT gives the instruction memory one settle cycle after a PC jump.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One fetched instruction together with its PC and the prediction made for it.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] instr;
        logic              pred_taken;
    } fetch_entry_t;

    // Instructions are word aligned: the two low address bits are always cleared.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetch entries. The head is read straight
// from the storage registers, so a pushed entry is visible the cycle after
// the push and an empty queue is never bypassed.
// Handshake: the caller pushes only when not full or when popping in the
// same cycle, and pops only when o_valid is high. Flush wins over both.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fetch_entry_t           i_entry,
    output fetch_entry_t           o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory,
// applies branch-predictor hints and EX redirects, and buffers fetched
// instructions for decode.
// Decode handshake: an entry transfers on a cycle where out_valid and
// out_ready are both high; head fields hold while out_valid & !out_ready.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        pred_taken,
    input  logic [63:0] pred_target,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_pred_taken,
    output state_t      o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    state_t          r_state;
    state_t          w_next_state;
    logic            w_in_run;
    logic            w_pop;
    logic            w_fire;
    logic            w_q_valid;
    logic [CW-1:0]   w_count;
    logic            w_not_full;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: BOOT lasts one cycle; a redirect always returns to BOOT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = BOOT;
        endcase
        if (redirect_valid) begin
            w_next_state = BOOT;
        end
    end

    // FSM outputs: fetch fires in RUN when there is room (or room is being
    // made by a pop) and no redirect is discarding the stream.
    always_comb begin
        w_in_run   = (r_state == RUN);
        w_not_full = (w_count != CW'(DEPTH));
        w_pop      = w_q_valid & out_ready & ~redirect_valid;
        w_fire     = w_in_run & ~redirect_valid & (w_not_full | w_pop);
    end

    // Next PC: redirect first, then predicted target or sequential step.
    always_comb begin
        w_next_pc = r_pc;
        if (redirect_valid) begin
            w_next_pc = align_pc(redirect_pc);
        end else if (w_fire) begin
            w_next_pc = pred_taken ? align_pc(pred_target) : (r_pc + PC_STEP);
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign w_push_entry = '{pc: r_pc, instr: imem_instr, pred_taken: pred_taken};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (redirect_valid),
        .i_push  (w_fire),
        .i_pop   (w_pop),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_valid (w_q_valid),
        .o_count (w_count)
    );

    assign imem_addr      = r_pc;
    assign out_valid      = w_q_valid;
    assign out_instr      = w_head.instr;
    assign out_pc         = w_head.pc;
    assign out_pred_taken = w_head.pred_taken;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        pred_taken = 1'b0;
    logic [63:0] pred_target = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_pred_taken;
    state_t      o_dbg_state;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Instruction memory contents: three fixed words, everything else derived from the address.
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00100093;
            64'h4:   return 32'hFE000EE3;
            64'h8:   return 32'h00140084;
            default: return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign imem_instr = mem_fn(imem_addr);

    // Reference model: PC, boot flag and a queue of pending entries.
    logic [63:0]  m_pc;
    bit           m_boot;
    bit           m_known;
    bit           m_after_rst;
    fetch_entry_t m_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit rst, input bit rdy, input bit pt, input logic [63:0] ptgt,
                        input bit rv, input logic [63:0] rpc);
        bit pop;
        bit fire;
        fetch_entry_t e;
        @(negedge clk);
        reset          = rst;
        out_ready      = rdy;
        pred_taken     = pt;
        pred_target    = ptgt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (m_known) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("run_state", 64'(o_dbg_state == RUN), 64'(!m_boot));
            chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("out_pc", out_pc, m_q[0].pc);
                chk("out_instr", 64'(out_instr), 64'(m_q[0].instr));
                chk("out_pred", 64'(out_pred_taken), 64'(m_q[0].pred_taken));
            end
            if (m_after_rst) begin
                chk("rst_instr", 64'(out_instr), 64'h0);
                chk("rst_pc", out_pc, 64'h0);
                chk("rst_pred", 64'(out_pred_taken), 64'h0);
            end
        end
        if (rst) begin
            m_pc    = RESET_PC;
            m_boot  = 1'b1;
            m_q.delete();
            m_known = 1'b1;
        end else if (rv) begin
            m_q.delete();
            m_pc   = rpc & ~64'h3;
            m_boot = 1'b1;
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            fire = !m_boot && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (fire) begin
                e.pc         = m_pc;
                e.instr      = mem_fn(m_pc);
                e.pred_taken = pt;
                m_q.push_back(e);
                m_pc = pt ? (ptgt & ~64'h3) : (m_pc + 64'd4);
            end
            m_boot = 1'b0;
        end
        m_after_rst = rst;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    initial begin
        m_known     = 1'b0;
        m_after_rst = 1'b0;
        m_boot      = 1'b1;
        m_pc        = RESET_PC;

        // Reset, then stream 0, 4, 8 with decode always ready.
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        idle(1'b1, 5);

        // Back-pressure from the first fetch: queue fills, PC holds, then drains in order.
        step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        idle(1'b0, 7);
        idle(1'b1, 6);

        // Predicted-taken loop 0, 4, 0, 4 ...
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, (m_pc == 64'h4), 64'h0, 1'b0, 64'h0);

        // Redirect to an unaligned target with two entries queued.
        idle(1'b0, 4);
        step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0000_0000_0000_000A);
        idle(1'b1, 5);

        // Full queue under continuous ready: one push and one pop per cycle.
        idle(1'b0, 4);
        idle(1'b1, 6);

        // PC wrap past the top of the address space.
        step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(1'b1, 5);

        // Reset mid-stream with two entries queued.
        idle(1'b0, 4);
        step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        idle(1'b1, 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0),
                 64'($urandom_range(0, 255)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF5 : 64'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that drives the byte address into the instruction memory and captures the returned 32-bit instruction.
- Owns the PC and buffers fetched instructions in a small FIFO, handing them to decode over a valid/ready handshake.
- Accepts branch-predictor hints (predicted taken + target) and EX-stage redirects (mispredict/flush).

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, fetch-queue entries (power of two, >= 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  byte address to instruction memory; equals PC register.
- imem_instr  in  32  instruction returned combinationally for imem_addr, little-endian.
- pred_taken  in  1  predictor says the instruction at current PC is a taken branch.
- pred_target  in  64  predicted target, valid with pred_taken.
- redirect_valid  in  1  EX-stage redirect (mispredict or flush).
- redirect_pc  in  64  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  64  head PC.
- out_pred_taken  out  1  prediction recorded with head.

Behaviour:
- Reset (synchronous, active-high): pc <= RESET_PC, state <= BOOT, queue count/pointers <= 0, out_valid = 0, out_instr = 0, out_pc = 0, out_pred_taken = 0. Reset mid-operation discards all queued entries the next edge.
- State BOOT: one cycle; imem_addr = pc, no push, pc unchanged. This gives the memory a full cycle to settle. Next state is RUN.
- State RUN: fetch fires when count < DEPTH, or when a pop happens this cycle (out_valid & out_ready), and there is no redirect.
- On fire: push {pc, imem_instr, pred_taken}. next pc = pred_taken ? pred_target : pc + 4.
- No fire, no redirect: pc holds; imem_addr stable.
- Redirect (highest priority, any state): queue flushed (count <= 0, out_valid = 0 next cycle), no push, pc <= {redirect_pc[63:2], 2'b00}, state <= BOOT. A pop in the same cycle is ignored, and its entry is lost with the flush.
- pred_target is force-aligned the same way: bits [1:0] cleared.
- PC arithmetic is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Latency: an instruction fetched in cycle N is visible at out_* in cycle N+1. An empty queue is never bypassed.
- Outputs are registered from queue storage. Head fields are held stable while out_valid & !out_ready.
- Full with no pop: no fire; pc and imem_addr held.
- Simultaneous push and pop when full: both occur, count unchanged.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package if_pkg: state enum {BOOT, RUN}, INST_W = 32, XLEN = 64, PC_STEP = 4, fetch-entry struct {pc, instr, pred_taken}.
- One sub-module, fetch_queue: a DEPTH-entry synchronous FIFO with push/pop/flush, count and registered head.
- PC/next-PC logic and the state machine stay in if_fetch_unit.

Test Plan:
- Reset with RESET_PC=0, memory model: addr 0 = 32'h00100093, 4 = 32'hFE000EE3, 8 = 32'h00140084; out_ready=1 -> BOOT 1 cycle, then out_pc = 0, 4, 8 on consecutive cycles with matching out_instr, out_valid = 1 from cycle 2.
- out_ready = 0 for 5 cycles after first fetch -> exactly 2 entries buffered (pcs 0, 4); imem_addr holds 8; on release out_pc = 0, 4, 8 with no duplicate or skip.
- pred_taken = 1, pred_target = 64'h0 while pc = 4 -> entry pc = 4 with out_pred_taken = 1, next fetched pc = 0 (loop 0, 4, 0, 4 …).
- redirect_valid = 1, redirect_pc = 64'h0000_0000_0000_000A with 2 entries queued -> out_valid = 0 next cycle, one BOOT cycle, then out_pc = 8 (aligned).
- Full queue, out_ready = 1 continuous -> one push and one pop per cycle, count stays at DEPTH, pc advances 4 per cycle.
- Assert reset mid-stream with 2 entries queued -> next cycle out_valid = 0, imem_addr = RESET_PC, BOOT then fetch restarts at RESET_PC.
